// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu -- load/store unit.
//
// Takes one decoded memory access from EX and runs it as a single transaction
// on a 64-bit bus with 8 byte lanes. The pipeline stalls while the access is
// in flight. Load data comes back shifted to bit 0 and sign- or zero-extended
// for RV64I.
//
// Ports:
//   clk, rst_n          core clock (rising edge), async active-low reset
//   req_valid           EX presents a memory instruction, held until done
//   mem_r, mem_w        load / store select from the decoder
//   funct3              access size and signedness (INST[14:12])
//   addr, wdata         effective byte address, store data (LSB aligned)
//   busy                combinational stall request to the pipeline
//   done                one-cycle completion pulse
//   rdata_out           extended load result, valid while done=1
//   misalign            misaligned-access flag, valid while done=1
//   bus_valid/ready     request handshake
//   bus_we, bus_addr    write flag, 8-byte aligned address
//   bus_wdata/wmask     lane-shifted store data and byte enables
//   bus_rsp_valid/rdata response or write acknowledge, full 8-byte read data
//
// Build option:
//   YSYX_22050243_LSU_MISALIGN_CHK_EN  when defined, a misaligned access skips
//   the bus and completes at once with misalign=1. When undefined, the low
//   offset bits are forced to natural alignment and the access proceeds.
module ysyx_22050243_lsu #(
   parameter int ADDR_W = 64,
   parameter int BUS_DW = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BUS_DW-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [BUS_DW-1:0] rdata_out,
   output logic              misalign,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [BUS_DW-1:0] bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_rsp_valid,
   input  logic [BUS_DW-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        off_q;
   logic [2:0]        funct3_q;

   logic              req_legal;
   logic              mis_hit;
   logic [2:0]        off_aligned;
   logic [7:0]        mask_base;
   logic [7:0]        lane_mask;
   logic [BUS_DW-1:0] lane_wdata;
   logic [BUS_DW-1:0] rd_shifted;
   logic [BUS_DW-1:0] load_ext;

   // Decode the incoming request: legality, misalignment, and the byte-lane
   // placement. funct3[1:0] is the access size for both loads and stores.
   always_comb begin
      req_legal   = 1'b0;
      mis_hit     = 1'b0;
      off_aligned = 3'b000;
      mask_base   = 8'h00;
      if (mem_r && !mem_w) begin
         req_legal = (funct3 != 3'b111);
      end else if (mem_w && !mem_r) begin
         req_legal = !funct3[2];
      end
      case (funct3[1:0])
         2'b00: begin
            off_aligned = addr[2:0];
            mask_base   = 8'h01;
         end
         2'b01: begin
            off_aligned = {addr[2:1], 1'b0};
            mask_base   = 8'h03;
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
            mis_hit     = addr[0];
`endif
         end
         2'b10: begin
            off_aligned = {addr[2], 2'b00};
            mask_base   = 8'h0F;
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
            mis_hit     = |addr[1:0];
`endif
         end
         default: begin
            off_aligned = 3'b000;
            mask_base   = 8'hFF;
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
            mis_hit     = |addr[2:0];
`endif
         end
      endcase
      lane_mask  = mask_base << off_aligned;
      lane_wdata = wdata << {off_aligned, 3'b000};
   end

   // Bring the addressed bytes of the returned word down to bit 0 and extend
   // them according to the captured funct3.
   always_comb begin
      rd_shifted = bus_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
         3'b001:  load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b010:  load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
         3'b011:  load_ext = rd_shifted;
         3'b100:  load_ext = {56'd0, rd_shifted[7:0]};
         3'b101:  load_ext = {48'd0, rd_shifted[15:0]};
         3'b110:  load_ext = {32'd0, rd_shifted[31:0]};
         default: load_ext = '0;
      endcase
   end

   // State register. Reset drops straight back to IDLE even mid-transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Requests are only sampled in IDLE; illegal or (when
   // checking is enabled) misaligned requests bypass the bus entirely. A
   // response is only looked at in WAIT, so one that coincides with the
   // accepting bus_ready is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = (req_legal && !mis_hit) ? REQ : DONE;
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus_rsp_valid) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs. bus_valid and done follow the state being entered so
   // they line up with REQ and DONE. Bus fields are captured once in IDLE and
   // then held untouched while the slave stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wmask <= 8'h00;
         done      <= 1'b0;
         rdata_out <= '0;
         misalign  <= 1'b0;
         off_q     <= 3'b000;
         funct3_q  <= 3'b000;
      end else begin
         bus_valid <= (state_d == REQ);
         done      <= (state_d == DONE);
         if (state_q == IDLE && req_valid) begin
            if (req_legal && !mis_hit) begin
               bus_we    <= mem_w;
               bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
               bus_wdata <= lane_wdata;
               bus_wmask <= lane_mask;
               off_q     <= off_aligned;
               funct3_q  <= funct3;
            end else begin
               rdata_out <= '0;
               misalign  <= req_legal & mis_hit;
            end
         end
         if (state_q == WAIT && bus_rsp_valid) begin
            rdata_out <= bus_we ? '0 : load_ext;
            misalign  <= 1'b0;
         end
      end
   end

   assign busy = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT);

endmodule
